siso_tx_arbiter: RTL and testbench
==================================

# siso_tx_arbiter

Shares one serial shift chain, a 4-stage SISO pipeline in the default build, between two parallel-word requesters. The block arbitrates round-robin and loads the granted word into a parallel-in/serial-out register. It drives the word MSB-first onto the chain input, then waits for the chain to drain. It acknowledges the requester only after the last bit has left the chain output.

## Interface
Parameters:
- W, default 8: word width; bits per transfer (W >= 2).
- DEPTH, default 4: stage count of the downstream shift chain; drain wait in cycles (DEPTH >= 0).

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- req0, input, 1: requester 0 transfer request; held until ack0.
- data0, input, W: requester 0 word; stable from req0 rise until ack0.
- req1, input, 1: requester 1 transfer request.
- data1, input, W: requester 1 word.
- ack0, output, 1: one-cycle pulse; requester 0 transfer complete.
- ack1, output, 1: one-cycle pulse; requester 1 transfer complete.
- sout, output, 1: serial bit to the shift chain (its din).
- sval, output, 1: high while sout carries a valid data bit.
- busy, output, 1: high whenever the FSM is not IDLE.
- owner, output, 1: id of the current or last granted requester.

## Operation
- The FSM has four states: IDLE, SHIFT, DRAIN and DONE.
- **IDLE:**
  - If no request is pending, remain in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester that is not `last`. `last` is a 1-bit round-robin pointer.
  - On grant, load the granted word into `shreg`, set owner and `last` to the granted id, set `bitcnt` = W-1, and go to SHIFT.
- **SHIFT:**
  - sout = shreg[W-1] and sval = 1. Shift `shreg` left each cycle, filling 0.
  - When `bitcnt` == 0, go to DRAIN, or to DONE if DEPTH == 0.
  - Otherwise decrement `bitcnt`.
  - DRAIN loads `dcnt` = DEPTH-1 on entry.
- **DRAIN:**
  - sval = 0 and sout = 0.
  - When `dcnt` == 0, go to DONE; otherwise decrement `dcnt`.
- **DONE:**
  - Assert ack[owner] for this cycle only, then go to IDLE.
  - Requests are not sampled in DONE.
- **Handshake:**
  - The requester deasserts req on the edge after it sees ack.
  - A req still high in the following IDLE cycle is a new transfer.
  - Data is sampled only at grant; changes after grant have no effect.
- **Counters:** `bitcnt` is clog2(W) bits and `dcnt` is max(1, clog2(DEPTH+1)) bits. Neither wraps; each is reloaded on entry to its state.
- **Outputs:** ack0 and ack1 are never high together. sval is never high outside SHIFT.
- **Reset:**
  - Values after reset: state = IDLE, shreg = 0, sout = 0, sval = 0, ack0 = ack1 = 0, busy = 0, owner = 0, `last` = 1. With `last` = 1, req0 wins the first contention.
  - Reset mid-transfer abandons the word with no ack. Bits already in the chain are not recalled.

## Timing
- Take edge E0 as the IDLE edge where a grant occurs.
- Cycles 1..W after E0 are SHIFT, with sout = data[W-1] .. data[0].
- Cycles W+1..W+DEPTH are DRAIN.
- Cycle W+DEPTH+1 is DONE, with ack high.
- Cycle W+DEPTH+2 is IDLE; the earliest next grant is at the end of that cycle.
- Transfer period is W+DEPTH+2 cycles, which is 14 for the defaults.
- The last bit, launched in cycle W, reaches the chain output in cycle W+DEPTH, one cycle before ack.
- busy rises in cycle 1 and falls at entry to IDLE; it is high in DONE.
- sout, sval, ack and busy are decoded from registered state only, with no input-to-output combinational path.

## Test plan
- **Reset:** hold rst for 3 cycles with req0 = 1 -> all outputs at reset values, no grant during reset. The first grant occurs at the IDLE edge after rst falls.
- **Single transfer:** req0 = 1, data0 = 8'hA5, defaults.
  - sval high for cycles 1..8 with sout = 1,0,1,0,0,1,0,1.
  - ack0 = 1 only in cycle 13; busy high in cycles 1..13.
  - A 4-stage chain model outputs the pattern in cycles 5..12.
- **Contention:** req0 and req1 both high continuously with data0 = 8'hF0, data1 = 8'h0F.
  - Grants alternate 0,1,0,1; owner follows.
  - Successive grants are 14 cycles apart.
  - Ack pulses alternate, and the serial patterns match the owners.
- **DEPTH = 0, W = 4:** req1 = 1, data1 = 4'b1001 -> sout = 1,0,0,1 in cycles 1..4, ack1 in cycle 5, no DRAIN cycles.
- **Reset mid-transfer:** assert rst in cycle 3 of a req0 transfer -> no ack0, outputs at reset values the next cycle. After reset, a pending req1 and req0 resolve to req0 (`last` = 1).
- **Data change after grant:** change data0 in cycle 2 -> the serial stream still shows the word sampled at E0.

Source files
------------

// File: rtl/siso_tx_arbiter.sv
// Round-robin arbiter that serialises one of two parallel words MSB-first onto a shared
// shift chain and acknowledges the requester once the chain has fully drained.
module siso_tx_arbiter #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic [W-1:0] data0,
   input  logic         req1,
   input  logic [W-1:0] data1,
   output logic         ack0,
   output logic         ack1,
   output logic         sout,
   output logic         sval,
   output logic         busy,
   output logic         owner
);

   localparam int unsigned BW = $clog2(W);
   localparam int unsigned DW = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);
   localparam logic [BW-1:0] BitLoad   = BW'(W - 1);
   localparam logic [DW-1:0] DrainLoad = (DEPTH == 0) ? '0 : DW'(DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDrain, StDone} state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  shreg_q, shreg_d;
   logic [BW-1:0] bitcnt_q, bitcnt_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic          owner_q, owner_d;
   logic          last_q, last_d;
   logic          grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         dcnt_q   <= '0;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         dcnt_q   <= dcnt_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      dcnt_d   = dcnt_q;
      owner_d  = owner_q;
      last_d   = last_q;
      grant    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               // Under contention the requester that did not win last time goes first.
               grant    = (req0 && req1) ? ~last_q : req1;
               shreg_d  = grant ? data1 : data0;
               owner_d  = grant;
               last_d   = grant;
               bitcnt_d = BitLoad;
               state_d  = StShift;
            end
         end
         StShift: begin
            shreg_d = {shreg_q[W-2:0], 1'b0};
            if (bitcnt_q == '0) begin
               if (DEPTH == 0) begin
                  state_d = StDone;
               end else begin
                  dcnt_d  = DrainLoad;
                  state_d = StDrain;
               end
            end else begin
               bitcnt_d = bitcnt_q - 1'b1;
            end
         end
         StDrain: begin
            if (dcnt_q == '0) begin
               state_d = StDone;
            end else begin
               dcnt_d = dcnt_q - 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // All outputs decode registered state only.
   assign sval  = (state_q == StShift);
   assign sout  = sval & shreg_q[W-1];
   assign busy  = (state_q != StIdle);
   assign ack0  = (state_q == StDone) & ~owner_q;
   assign ack1  = (state_q == StDone) & owner_q;
   assign owner = owner_q;

endmodule

// File: tb/tb_siso_tx_arbiter.sv
// Bench for siso_tx_arbiter: a default build and a W=4/DEPTH=0 build driven by randomized
// requesters and checked every cycle against a transfer-level timing model.
module tb_siso_tx_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       r0 [2];
   logic       r1 [2];
   logic [7:0] d0 [2];
   logic [7:0] d1 [2];
   logic       a0 [2];
   logic       a1 [2];
   logic       so [2];
   logic       sv [2];
   logic       bz [2];
   logic       ow [2];

   siso_tx_arbiter #(.W(8), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .req0(r0[0]), .data0(d0[0]), .req1(r1[0]), .data1(d1[0]),
      .ack0(a0[0]), .ack1(a1[0]), .sout(so[0]), .sval(sv[0]), .busy(bz[0]), .owner(ow[0])
   );

   siso_tx_arbiter #(.W(4), .DEPTH(0)) dut_d0 (
      .clk(clk), .rst(rst),
      .req0(r0[1]), .data0(d0[1][3:0]), .req1(r1[1]), .data1(d1[1][3:0]),
      .ack0(a0[1]), .ack1(a1[1]), .sout(so[1]), .sval(sv[1]), .busy(bz[1]), .owner(ow[1])
   );

   int n_checks = 0;
   int n_pass   = 0;
   int mode;

   // Model: mt = cycle number within the current transfer (0 when idle).
   int         mt    [2];
   logic       mown  [2];
   logic       mlast [2];
   logic [7:0] mword [2];
   int         xfer  [2];

   // 4-stage chain model behind the default build, tagged by transfer number.
   logic       hsv [4];
   logic       hso [4];
   int         hid [4];
   int         ccnt;
   logic [7:0] cword;

   function automatic int w_of(input int k);
      return (k == 0) ? 8 : 4;
   endfunction

   function automatic int d_of(input int k);
      return (k == 0) ? 4 : 0;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_edge(input int k);
      logic g;
      if (rst) begin
         mt[k]    = 0;
         mlast[k] = 1'b1;
         mown[k]  = 1'b0;
      end else if (mt[k] == 0) begin
         if (r0[k] || r1[k]) begin
            g        = (r0[k] && r1[k]) ? !mlast[k] : r1[k];
            mword[k] = g ? d1[k] : d0[k];
            if (k == 1) mword[k][7:4] = 4'h0;
            mown[k]  = g;
            mlast[k] = g;
            mt[k]    = 1;
            xfer[k]++;
            if (k == 0) ccnt = 0;
         end
      end else if (mt[k] == w_of(k) + d_of(k) + 1) begin
         mt[k] = 0;
      end else begin
         mt[k]++;
      end
   endtask

   task automatic check_outputs(input int k);
      int   ww;
      logic esv, eso, edone;
      ww    = w_of(k);
      esv   = (mt[k] >= 1) && (mt[k] <= ww);
      eso   = esv ? mword[k][ww - mt[k]] : 1'b0;
      edone = (mt[k] == ww + d_of(k) + 1);
      check_eq($sformatf("sval%0d", k), 32'(sv[k]), 32'(esv));
      check_eq($sformatf("sout%0d", k), 32'(so[k]), 32'(eso));
      check_eq($sformatf("busy%0d", k), 32'(bz[k]), 32'(mt[k] != 0));
      check_eq($sformatf("ack0_%0d", k), 32'(a0[k]), 32'(edone && !mown[k]));
      check_eq($sformatf("ack1_%0d", k), 32'(a1[k]), 32'(edone && mown[k]));
      check_eq($sformatf("owner%0d", k), 32'(ow[k]), 32'(mown[k]));
   endtask

   task automatic chain_update();
      if (hsv[3] && hid[3] == xfer[0]) begin
         cword = {cword[6:0], hso[3]};
         ccnt++;
      end
      if (mt[0] == 13) begin
         check_eq("chain_bits", 32'(ccnt), 32'd8);
         check_eq("chain_word", 32'(cword), 32'(mword[0]));
         if (mode == 0) check_eq("first_word_a5", 32'(cword), 32'hA5);
      end
      for (int i = 3; i > 0; i--) begin
         hsv[i] = hsv[i-1];
         hso[i] = hso[i-1];
         hid[i] = hid[i-1];
      end
      hsv[0] = sv[0];
      hso[0] = so[0];
      hid[0] = xfer[0];
   endtask

   task automatic drive();
      for (int k = 0; k < 2; k++) begin
         logic e0, e1;
         e0 = (mt[k] == w_of(k) + d_of(k) + 1) && !mown[k];
         e1 = (mt[k] == w_of(k) + d_of(k) + 1) && mown[k];
         if (mode == 0) begin
            if (e0) r0[k] = 1'b0;
            if (e1) r1[k] = 1'b0;
            // Corrupt the granted word after grant; the stream must not change.
            if (mt[k] == 2) begin
               if (mown[k]) d1[k] = ~d1[k];
               else d0[k] = ~d0[k];
            end
         end else if (mode == 1) begin
            r0[k] = 1'b1;
            r1[k] = 1'b1;
            d0[k] = (k == 0) ? 8'hF0 : 8'h0C;
            d1[k] = (k == 0) ? 8'h0F : 8'h03;
         end else begin
            if (e0) begin
               r0[k] = 1'($urandom_range(0, 1));
               d0[k] = 8'($urandom);
            end else if (!r0[k] && $urandom_range(0, 3) == 0) begin
               r0[k] = 1'b1;
               d0[k] = 8'($urandom);
            end
            if (e1) begin
               r1[k] = 1'($urandom_range(0, 1));
               d1[k] = 8'($urandom);
            end else if (!r1[k] && $urandom_range(0, 3) == 0) begin
               r1[k] = 1'b1;
               d1[k] = 8'($urandom);
            end
            if (mt[k] >= 2 && mt[k] <= 3 && $urandom_range(0, 1) == 1) begin
               if (mown[k]) d1[k] = 8'($urandom);
               else d0[k] = 8'($urandom);
            end
         end
      end
      if (mode == 2) rst = ($urandom_range(0, 99) == 0);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check_outputs(0);
      check_outputs(1);
      chain_update();
      drive();
   endtask

   initial begin
      rst   = 1'b1;
      r0[0] = 1'b1;  d0[0] = 8'hA5;  r1[0] = 1'b0;  d1[0] = 8'h00;
      r0[1] = 1'b0;  d0[1] = 8'h00;  r1[1] = 1'b1;  d1[1] = 8'h09;
      for (int k = 0; k < 2; k++) begin
         mt[k]    = 0;
         mown[k]  = 1'b0;
         mlast[k] = 1'b1;
         mword[k] = 8'h00;
         xfer[k]  = 0;
      end
      for (int i = 0; i < 4; i++) begin
         hsv[i] = 1'b0;
         hso[i] = 1'b0;
         hid[i] = -1;
      end
      ccnt  = 0;
      cword = 8'h00;
      mode  = 0;
      repeat (3) step();
      rst = 1'b0;
      repeat (25) step();
      mode = 1;
      repeat (60) step();
      mode = 2;
      repeat (3000) step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
